// File: rtl/rotate_pkg.sv
// Shared constants for the rotation datapath: default coefficient table geometry
// and the coefficient loader FSM state encoding.
package rotate_pkg;

    localparam int ROT_ADDR_WIDTH = 8;
    localparam int ROT_DATA_WIDTH = 18;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/rotate_coef_chk.sv
// Read-back checker for the coefficient loader: sums written words, sweeps the RAM
// and compares sums. Only built when ROTATE_COEF_LOADER_VERIFY_EN is defined.
`ifdef ROTATE_COEF_LOADER_VERIFY_EN
module rotate_coef_chk #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  clr,
    input  logic                  beat_vld,
    input  logic [DATA_WIDTH-1:0] beat_dat,
    input  logic                  go,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  chk_done,
    output logic                  chk_err
);

    localparam int SW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [SW-1:0]         wsum_q, wsum_d, rsum_q, rsum_d, rsum_next;
    logic [ADDR_WIDTH:0]   beats_q, beats_d, idx_q, idx_d;
    logic                  active_q, active_d, issue_last;
    logic [RD_LATENCY-1:0] pv_q, pv_d, pl_q, pl_d;
    logic                  chk_err_q, chk_err_d;

    assign rsum_next  = rsum_q + {{ADDR_WIDTH{1'b0}}, rd_data};
    assign issue_last = active_q && (idx_q == beats_q - CNT_ONE);
    assign chk_done   = pv_q[RD_LATENCY-1] & pl_q[RD_LATENCY-1];
    assign rd_addr    = idx_q[ADDR_WIDTH-1:0];
    assign chk_err    = chk_err_q;

    always_comb begin
        wsum_d    = wsum_q;
        rsum_d    = rsum_q;
        beats_d   = beats_q;
        idx_d     = idx_q;
        active_d  = active_q;
        chk_err_d = chk_err_q;
        pv_d      = pv_q;
        pl_d      = pl_q;

        if (clr) begin
            wsum_d    = '0;
            beats_d   = '0;
            chk_err_d = 1'b0;
        end else if (beat_vld) begin
            wsum_d  = wsum_q + {{ADDR_WIDTH{1'b0}}, beat_dat};
            beats_d = beats_q + CNT_ONE;
        end

        // go coincides with the final beat, so beats_q is complete once the sweep runs
        if (go) begin
            active_d = 1'b1;
            idx_d    = '0;
            rsum_d   = '0;
        end else if (active_q) begin
            idx_d = idx_q + CNT_ONE;
            if (issue_last) active_d = 1'b0;
        end

        pv_d[0] = active_q;
        pl_d[0] = issue_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
        end

        if (pv_q[RD_LATENCY-1]) rsum_d = rsum_next;
        if (chk_done && (rsum_next != wsum_q)) chk_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wsum_q    <= '0;
            rsum_q    <= '0;
            beats_q   <= '0;
            idx_q     <= '0;
            active_q  <= 1'b0;
            chk_err_q <= 1'b0;
            pv_q      <= '0;
            pl_q      <= '0;
        end else begin
            wsum_q    <= wsum_d;
            rsum_q    <= rsum_d;
            beats_q   <= beats_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            chk_err_q <= chk_err_d;
            pv_q      <= pv_d;
            pl_q      <= pl_d;
        end
    end

endmodule
`endif

// File: rtl/rotate_coef_loader.sv
// Fills the rotation coefficient RAM from a valid/ready stream; one write per handshake,
// 1-cycle write latency. Optional read-back verify under ROTATE_COEF_LOADER_VERIFY_EN.
module rotate_coef_loader
    import rotate_pkg::*;
#(
    parameter int ADDR_WIDTH = ROT_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROT_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err
`ifdef ROTATE_COEF_LOADER_VERIFY_EN
    ,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  chk_err
`endif
);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("rotate_coef_loader: RD_LATENCY must be 1 or 2");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  s_ready_q, s_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  len_err_q, len_err_d;

    logic hs, last_beat, final_beat, start_ok;

    assign hs         = s_valid & s_ready_q;
    assign last_beat  = (count_q == LAST_ADDR);
    assign final_beat = hs & (s_last | last_beat);
    assign start_ok   = start & (state_q == ST_IDLE);

`ifdef ROTATE_COEF_LOADER_VERIFY_EN
    logic chk_done;

    rotate_coef_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_chk (
        .clk      (clk),
        .tb_rst   (tb_rst),
        .clr      (start_ok),
        .beat_vld (hs),
        .beat_dat (s_data),
        .go       (final_beat),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .chk_done (chk_done),
        .chk_err  (chk_err)
    );
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        len_err_d = len_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    count_d   = '0;
                    len_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = s_data;
                    if (final_beat) begin
`ifdef ROTATE_COEF_LOADER_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        state_d = ST_DONE;
`endif
                        // Early s_last or a missing s_last on the last address both end the load
                        len_err_d = len_err_q | (s_last ^ last_beat);
                    end else begin
                        count_d = count_q + ADDR_ONE;
                    end
                end
            end
`ifdef ROTATE_COEF_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (chk_done) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign len_err = len_err_q;

endmodule

// File: doc/rotate_coef_loader.md
Name: rotate_coef_loader

Overview:
- Writer-side counterpart of the rotation coefficient ROM: fills a DATA_WIDTH x 2**ADDR_WIDTH coefficient RAM (cos/sin table) from a valid/ready stream at run time.
- Sits between the host/config path and the rotation engine's coefficient memory. Replaces init-file-only tables so zoom/rotate tables can be reloaded without a rebuild.
- Generates sequential write addresses, checks stream length, and signals completion.

Parameters:
- ADDR_WIDTH, 8, coefficient RAM address width; table depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 18, coefficient word width.
- RD_LATENCY, 1, RAM read latency in cycles (1 or 2); used only with the verify feature.

Ports:
- clk  in  1  clock.
- tb_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load when idle.
- s_valid  in  1  stream data valid.
- s_ready  out  1  loader accepts data.
- s_data  in  DATA_WIDTH  coefficient word.
- s_last  in  1  marks the final word of the stream.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- len_err  out  1  sticky; stream length does not equal N. Cleared by the next accepted start.

Behaviour:
- Reset (tb_rst=1, async): state=IDLE. All outputs 0: s_ready, wr_en, wr_addr, wr_data, busy, done, len_err. Beat counter 0.
- FSM states: IDLE, LOAD, (VERIFY), DONE.
- IDLE:
  - s_ready=0.
  - start=1 -> LOAD next cycle; beat counter cleared, len_err cleared, busy=1.
- LOAD:
  - s_ready=1 (registered; equals state==LOAD).
  - Handshake = s_valid & s_ready.
  - Each handshake drives the registered write outputs on the next cycle: wr_en=1, wr_addr=count, wr_data=s_data. The counter then increments.
  - Write latency is exactly 1 cycle, and there is no stall: one write per handshake.
  - Final beat (count==N-1) with s_last=1 -> DONE.
  - Final beat with s_last=0 -> len_err=1, then DONE; excess words are never accepted.
  - s_last=1 with count<N-1 -> len_err=1, then DONE. The remaining addresses are left unwritten.
  - Counter never wraps; wr_addr never exceeds N-1.
- DONE: one cycle, done=1, busy=0 on exit, then IDLE.
- start while busy is ignored. start in the same cycle as the DONE->IDLE transition is ignored; start must be asserted while in IDLE.
- s_data/s_last are sampled only on a handshake.
- Reset mid-load aborts the load immediately; RAM contents are unspecified and no done pulse is produced.

Optional Feature:
- Macro: ROTATE_COEF_LOADER_VERIFY_EN.
- Defined:
  - Extra ports: rd_addr out ADDR_WIDTH, rd_data in DATA_WIDTH, chk_err out 1 (sticky, reset 0, cleared on start).
  - During LOAD, s_data is accumulated into a (DATA_WIDTH+ADDR_WIDTH)-bit modular sum.
  - After the final beat the FSM enters VERIFY instead of DONE. It sweeps rd_addr over 0..count-1, one per cycle, and sums rd_data RD_LATENCY cycles after each address.
  - When the last sample has been summed, the two sums are compared; mismatch -> chk_err=1. Then DONE.
  - done is delayed by count+RD_LATENCY+1 cycles.
- Undefined: no extra ports; LOAD goes directly to DONE.

Decomposition:
- Shared package rotate_pkg:
  - FSM state encoding (IDLE=0, LOAD=1, VERIFY=2, DONE=3).
  - Default ADDR_WIDTH/DATA_WIDTH constants, shared with rotate_rom and the rotation engine.
- One natural sub-module: rotate_coef_chk, holding the accumulator, read-address sweep and RD_LATENCY-deep valid pipeline. It is instantiated only under the macro.

Test Plan:
- Normal load: start, 256 words 0x00000..0x000FF with s_valid continuous and s_last on word 255 -> 256 wr_en pulses, wr_addr 0..255 with wr_data==addr, done 1 cycle after the last write, len_err=0.
- Backpressure/gaps: s_valid toggled randomly -> wr_en only on handshakes, addresses contiguous, final state identical to the continuous case.
- Short stream: s_last on word 99 -> 100 writes (addr 0..99), len_err=1, done pulse, s_ready=0 afterwards.
- Missing s_last: 256 words with s_last never set -> exactly 256 writes, len_err=1, word 257 not accepted (s_ready=0).
- Reset mid-load: assert tb_rst after 50 writes -> all outputs 0 within the same cycle (async), no done; a subsequent start reloads from addr 0.
- With ROTATE_COEF_LOADER_VERIFY_EN and a behavioural RAM model: load all words 0x3FFFF -> chk_err=0. Corrupt RAM word 17 after it is written -> chk_err=1. done arrives 256+RD_LATENCY+1 cycles after the last write.
